quadrature_gen: RTL and testbench

QUADRATURE_GEN -- requirements
Module: quadrature_gen

---
 rtl/quadrature_gen.sv | 139 +++++++++++++
 tb/tb_quadrature_gen.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_gen.sv
// -----------------------------------------------------------------------------
// quadrature_gen
//   Emits a two-bit Gray-coded quadrature pattern {B,A} that mimics a rotary
//   encoder turning a commanded number of steps in a chosen direction. It is
//   meant to drive the rotary input of a rotary decoder. One Gray step is
//   emitted every PHASE_CYCLES clocks, and a signed running step total is kept.
//
// Ports
//   clock0     in   clock, all state updates on the rising edge
//   reset      in   asynchronous active-high reset
//   cmd_valid  in   command request (accepted only when cmd_ready)
//   cmd_dir    in   0 = clockwise, 1 = counter-clockwise
//   cmd_count  in   number of quadrature steps to emit
//   abort      in   stop the active command (only effective while busy)
//   cmd_ready  out  idle, a command can be accepted
//   rotary     out  quadrature pair {B,A}
//   busy       out  command executing
//   done       out  one-cycle completion pulse
//   aborted    out  last command ended by abort (valid with done)
//   position   out  signed running step total (wraps modulo 2^16)
// -----------------------------------------------------------------------------
module quadrature_gen #(
    parameter int PHASE_CYCLES = 16,
    parameter int COUNT_WIDTH  = 8
) (
    input  logic                   clock0,
    input  logic                   reset,
    input  logic                   cmd_valid,
    input  logic                   cmd_dir,
    input  logic [COUNT_WIDTH-1:0] cmd_count,
    input  logic                   abort,
    output logic                   cmd_ready,
    output logic [1:0]             rotary,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [15:0]            position
);

    localparam logic [15:0] RELOAD = 16'(PHASE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

    state_t                 state_q, state_d;
    logic [15:0]            timer_q, timer_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                   dir_q, dir_d;
    logic [1:0]             rotary_q, rotary_d;
    logic [15:0]            position_q, position_d;
    logic                   done_q, done_d;
    logic                   aborted_q, aborted_d;

    // One Gray step from the current code. CW walks 00->01->11->10, CCW the
    // reverse; in both cases exactly one bit flips.
    function automatic logic [1:0] gray_step(input logic [1:0] c, input logic ccw);
        return ccw ? {~c[0], c[1]} : {c[0], ~c[1]};
    endfunction

    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            rotary_q    <= 2'b00;
            position_q  <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            rotary_q    <= rotary_d;
            position_q  <= position_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        rotary_d    = rotary_q;
        position_d  = position_q;
        done_d      = 1'b0;
        aborted_d   = aborted_q;

        case (state_q)
            IDLE: begin
                // abort is irrelevant here; a simultaneous command still goes in
                if (cmd_valid) begin
                    dir_d       = cmd_dir;
                    remaining_d = cmd_count;
                    aborted_d   = 1'b0;
                    timer_d     = RELOAD;
                    state_d     = (cmd_count == '0) ? DONE : HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    // abort beats a coincident step: code and position hold
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (timer_q == '0) begin
                    rotary_d    = gray_step(rotary_q, dir_q);
                    position_d  = dir_q ? position_q - 16'd1 : position_q + 16'd1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == COUNT_WIDTH'(1)) begin
                        state_d = DONE;
                    end else begin
                        timer_d = RELOAD;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            DONE: begin
                // first DONE cycle raises the registered pulse, second leaves
                if (!done_q) begin
                    done_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == HOLD);
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign rotary    = rotary_q;
    assign position  = position_q;

endmodule

// File: tb/tb_quadrature_gen.sv
module tb_quadrature_gen;
    localparam int P  = 4;
    localparam int CW = 8;

    logic          clock0, reset, cmd_valid, cmd_dir, abort;
    logic [CW-1:0] cmd_count;
    logic          cmd_ready, busy, done, aborted;
    logic [1:0]    rotary;
    logic [15:0]   position;

    quadrature_gen #(.PHASE_CYCLES(P), .COUNT_WIDTH(CW)) dut (
        .clock0(clock0), .reset(reset), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
        .cmd_count(cmd_count), .abort(abort), .cmd_ready(cmd_ready),
        .rotary(rotary), .busy(busy), .done(done), .aborted(aborted),
        .position(position)
    );

    initial clock0 = 1'b0;
    always #5 clock0 = ~clock0;

    // cyc = number of rising edges seen; at a falling edge it names the last edge
    int cyc = 0;
    always @(posedge clock0) cyc <= cyc + 1;

    typedef struct {
        int          at_edge;
        logic [1:0]  code;
        logic [15:0] pos;
    } step_t;

    step_t       exp_q[$];
    int          done_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  m_rot  = 2'b00;
    logic [15:0] m_pos  = 16'h0000;
    logic [1:0]  prev_rot;

    // Reference Gray sequence as an explicit table
    function automatic logic [1:0] nxt(input logic [1:0] c, input logic ccw);
        logic [1:0] r;
        case ({ccw, c})
            3'b0_00: r = 2'b01;
            3'b0_01: r = 2'b11;
            3'b0_11: r = 2'b10;
            3'b0_10: r = 2'b00;
            3'b1_00: r = 2'b10;
            3'b1_10: r = 2'b11;
            3'b1_11: r = 2'b01;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    // Queue k expected steps of a command accepted at edge n
    task automatic push_steps(input logic d, input int n, input int k);
        for (int i = 1; i <= k; i++) begin
            m_rot = nxt(m_rot, d);
            m_pos = d ? m_pos - 16'd1 : m_pos + 16'd1;
            exp_q.push_back('{n + i * P, m_rot, m_pos});
        end
    endtask

    // Call at a falling edge; command is sampled at the next rising edge
    task automatic issue(input logic d, input int cnt, input int hold);
        cmd_dir   = d;
        cmd_count = CW'(cnt);
        cmd_valid = 1'b1;
        repeat (hold) @(negedge clock0);
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && t < 400) begin
            @(negedge clock0);
            t++;
        end
        checks++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending steps %0d dones %0d, required 0 0",
                     name, exp_q.size(), done_q.size());
            exp_q.delete();
            done_q.delete();
        end
        @(negedge clock0);
    endtask

    // Scoreboard consumer: every rotary change and done pulse must match the
    // head of its queue, including the edge it happened on.
    always @(negedge clock0) begin
        step_t e;
        int    de;
        if (reset) begin
            prev_rot = rotary;
        end else begin
            if (rotary !== prev_rot) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_step edge %0d rotary %b pos %h", cyc, rotary, position);
                end else begin
                    e = exp_q.pop_front();
                    if (e.at_edge != cyc || rotary !== e.code || position !== e.pos) begin
                        errors++;
                        $display("FAIL step edge/rotary/pos got %0d %b %h, required %0d %b %h",
                                 cyc, rotary, position, e.at_edge, e.code, e.pos);
                    end
                end
                checks++;
                if ($countones(rotary ^ prev_rot) != 1) begin
                    errors++;
                    $display("FAIL gray_one_bit %b->%b, required one bit change", prev_rot, rotary);
                end
                prev_rot = rotary;
            end
            if (done === 1'b1) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done edge %0d", cyc);
                end else begin
                    de = done_q.pop_front();
                    if (de != cyc) begin
                        errors++;
                        $display("FAIL done_edge got %0d, required %0d", cyc, de);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clock0);
        checks++;
        if (rotary !== 2'b00 || position !== 16'h0000 || cmd_ready !== 1'b1 ||
            busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got rot %b pos %h rdy %b busy %b done %b, required 00 0000 1 0 0",
                     rotary, position, cmd_ready, busy, done);
        end
        reset = 1'b0;
    endtask

    task automatic test_cw();
        int n;
        @(negedge clock0);
        n = cyc + 1;
        push_steps(1'b0, n, 3);
        done_q.push_back(n + 3 * P + 1);
        issue(1'b0, 3, 1);
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL cw_busy got busy %b rdy %b, required 1 0", busy, cmd_ready);
        end
        drain("cw");
        checks++;
        if (position !== 16'h0003 || aborted !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cw_end got pos %h ab %b rdy %b, required 0003 0 1", position, aborted, cmd_ready);
        end
    endtask

    task automatic test_ccw();
        int n;
        @(negedge clock0);
        n = cyc + 1;
        push_steps(1'b1, n, 5);
        done_q.push_back(n + 5 * P + 1);
        issue(1'b1, 5, 1);
        drain("ccw");
        checks++;
        if (position !== 16'hFFFE || rotary !== 2'b11) begin
            errors++;
            $display("FAIL ccw_end got pos %h rot %b, required fffe 11", position, rotary);
        end
    endtask

    // Zero count; cmd_valid also held through the DONE cycle, which must not
    // start a second command.
    task automatic test_zero();
        int n;
        @(negedge clock0);
        n = cyc + 1;
        done_q.push_back(n + 1);
        issue(1'b0, 0, 2);
        drain("zero");
        checks++;
        if (aborted !== 1'b0 || rotary !== m_rot || position !== m_pos) begin
            errors++;
            $display("FAIL zero_end got ab %b rot %b pos %h, required 0 %b %h",
                     aborted, rotary, position, m_rot, m_pos);
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        @(negedge clock0);
        n = cyc + 1;
        push_steps(1'b0, n, 2);
        done_q.push_back(n + 2 * P + 1);
        issue(1'b0, 2, 1);
        @(negedge clock0);
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready got %b, required 0", cmd_ready);
        end
        issue(1'b1, 7, 1);
        drain("busy_ignore");
        checks++;
        if (position !== m_pos) begin
            errors++;
            $display("FAIL busy_ignore_pos got %h, required %h", position, m_pos);
        end
    endtask

    task automatic test_idle_abort();
        int n;
        @(negedge clock0);
        abort = 1'b1;
        @(negedge clock0);
        abort = 1'b0;
        repeat (2) @(negedge clock0);
        n = cyc + 1;
        push_steps(1'b0, n, 1);
        done_q.push_back(n + P + 1);
        abort = 1'b1;
        issue(1'b0, 1, 1);
        abort = 1'b0;
        drain("idle_abort");
        checks++;
        if (aborted !== 1'b0) begin
            errors++;
            $display("FAIL idle_abort_flag got %b, required 0", aborted);
        end
    endtask

    task automatic test_abort(input string name, input int at);
        int n;
        @(negedge clock0);
        n = cyc + 1;
        push_steps(1'b0, n, 1);
        done_q.push_back(n + at + 1);
        issue(1'b0, 10, 1);
        while (cyc < n + at - 1) @(negedge clock0);
        abort = 1'b1;
        @(negedge clock0);
        abort = 1'b0;
        drain(name);
        checks++;
        if (aborted !== 1'b1 || position !== m_pos || rotary !== m_rot) begin
            errors++;
            $display("FAIL %s_end got ab %b pos %h rot %b, required 1 %h %b",
                     name, aborted, position, rotary, m_pos, m_rot);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clock0);
        n = cyc + 1;
        push_steps(1'b0, n, 1);
        issue(1'b0, 10, 1);
        checks++;
        if (aborted !== 1'b0) begin
            errors++;
            $display("FAIL accept_clears_aborted got %b, required 0", aborted);
        end
        while (cyc < n + P + 2) @(negedge clock0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_first_step pending %0d, required 0", exp_q.size());
        end
        exp_q.delete();
        done_q.delete();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (rotary !== 2'b00 || position !== 16'h0000 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid got rot %b pos %h busy %b rdy %b, required 00 0000 0 1",
                     rotary, position, busy, cmd_ready);
        end
        m_rot = 2'b00;
        m_pos = 16'h0000;
        repeat (2) @(negedge clock0);
        reset = 1'b0;
        repeat (3 * P) @(negedge clock0);
    endtask

    task automatic test_after_reset();
        int n;
        @(negedge clock0);
        n = cyc + 1;
        push_steps(1'b0, n, 2);
        done_q.push_back(n + 2 * P + 1);
        issue(1'b0, 2, 1);
        drain("after_reset");
        checks++;
        if (position !== 16'h0002 || rotary !== 2'b11) begin
            errors++;
            $display("FAIL after_reset_end got pos %h rot %b, required 0002 11", position, rotary);
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_count = '0;
        abort     = 1'b0;
        test_reset();
        test_cw();
        test_ccw();
        test_zero();
        test_busy_ignore();
        test_idle_abort();
        test_abort("abort_mid", 6);
        test_abort("abort_step", 2 * P);
        test_reset_mid();
        test_after_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
